// File: rtl/enigma_core.sv
// ---------------------------------------------------------------------------
// enigma_core
//   Three-rotor Enigma I cipher engine: rotors I-II-III (left to right),
//   reflector B, ring settings fixed at A.  One plaintext symbol per cycle in,
//   enciphered symbol out a fixed two cycles later.
//
//   Handshake: a symbol is taken on any rising edge where en_val_i = 1,
//   load_i = 0 and 1 <= in_en_i <= 26.  There is no backpressure; the result
//   appears with encod_val_o = 1 exactly two cycles after acceptance.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        asynchronous active-high reset
//   in_en_i      plaintext symbol, 1..26 (A..Z)
//   en_val_i     in_en_i valid this cycle
//   load_i       load rotor start positions from pos_*_i (beats en_val_i)
//   pos_l_i      left rotor start position, 0..25 (larger values clamp to 25)
//   pos_m_i      middle rotor start position
//   pos_r_i      right rotor start position
//   out_en_o     enciphered symbol, 1..26; 0 when not valid
//   encod_val_o  out_en_o valid
//   wrg_symb_o   one-cycle pulse: the symbol presented last cycle was dropped
//   pos_o        registered rotor positions {l, m, r}
// ---------------------------------------------------------------------------
module enigma_core #(
    parameter int SYMB_W = 7
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [SYMB_W-1:0] in_en_i,
    input  logic              en_val_i,
    input  logic              load_i,
    input  logic [4:0]        pos_l_i,
    input  logic [4:0]        pos_m_i,
    input  logic [4:0]        pos_r_i,
    output logic [SYMB_W-1:0] out_en_o,
    output logic              encod_val_o,
    output logic              wrg_symb_o,
    output logic [14:0]       pos_o
);

    // Wiring tables, index 0 = A.
    localparam logic [4:0] ROT_I [26] = '{5'd4, 5'd10, 5'd12, 5'd5, 5'd11, 5'd6, 5'd3, 5'd16, 5'd21,
        5'd25, 5'd13, 5'd19, 5'd14, 5'd22, 5'd24, 5'd7, 5'd23, 5'd20, 5'd18, 5'd15, 5'd0, 5'd8,
        5'd1, 5'd17, 5'd2, 5'd9};
    localparam logic [4:0] ROT_II [26] = '{5'd0, 5'd9, 5'd3, 5'd10, 5'd18, 5'd8, 5'd17, 5'd20, 5'd23,
        5'd1, 5'd11, 5'd7, 5'd22, 5'd19, 5'd12, 5'd2, 5'd16, 5'd6, 5'd25, 5'd13, 5'd15, 5'd24,
        5'd21, 5'd14, 5'd4, 5'd5};
    localparam logic [4:0] ROT_III [26] = '{5'd1, 5'd3, 5'd5, 5'd7, 5'd9, 5'd11, 5'd2, 5'd15, 5'd17,
        5'd19, 5'd23, 5'd21, 5'd25, 5'd13, 5'd24, 5'd4, 5'd8, 5'd22, 5'd6, 5'd0, 5'd10, 5'd12,
        5'd20, 5'd18, 5'd16, 5'd14};
    localparam logic [4:0] REF_B [26] = '{5'd24, 5'd17, 5'd20, 5'd7, 5'd16, 5'd18, 5'd11, 5'd3, 5'd15,
        5'd23, 5'd13, 5'd6, 5'd14, 5'd10, 5'd12, 5'd8, 5'd4, 5'd1, 5'd5, 5'd25, 5'd2, 5'd22,
        5'd21, 5'd9, 5'd0, 5'd19};

    localparam logic [1:0] SEL_I   = 2'd0;
    localparam logic [1:0] SEL_II  = 2'd1;
    localparam logic [1:0] SEL_III = 2'd2;
    localparam logic [1:0] SEL_REF = 2'd3;

    localparam logic [4:0] NOTCH_M = 5'd4;   // E on rotor II
    localparam logic [4:0] NOTCH_R = 5'd21;  // V on rotor III

    // Operands are always 0..25, so one conditional subtract keeps results in range.
    function automatic logic [4:0] add26(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 6'd26) s = s - 6'd26;
        return s[4:0];
    endfunction

    // Adds 26 before subtracting so the intermediate never goes negative.
    function automatic logic [4:0] sub26(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] s;
        s = {1'b0, a} + 6'd26 - {1'b0, b};
        if (s >= 6'd26) s = s - 6'd26;
        return s[4:0];
    endfunction

    function automatic logic [4:0] lut(input logic [1:0] sel, input logic [4:0] idx);
        logic [4:0] v;
        case (sel)
            SEL_I:   v = ROT_I[idx];
            SEL_II:  v = ROT_II[idx];
            SEL_III: v = ROT_III[idx];
            default: v = REF_B[idx];
        endcase
        return v;
    endfunction

    function automatic logic [4:0] rot_fwd(input logic [1:0] sel, input logic [4:0] c,
                                           input logic [4:0] p);
        return sub26(lut(sel, add26(c, p)), p);
    endfunction

    // Inverse wiring is found by matching against the forward table, which
    // keeps a single source of truth for each rotor.
    function automatic logic [4:0] rot_inv(input logic [1:0] sel, input logic [4:0] c,
                                           input logic [4:0] p);
        logic [4:0] x;
        logic [4:0] j;
        x = add26(c, p);
        j = 5'd0;
        for (int k = 0; k < 26; k++) begin
            if (lut(sel, 5'(k)) == x) j = 5'(k);
        end
        return sub26(j, p);
    endfunction

    function automatic logic [4:0] inc26(input logic [4:0] a);
        return (a == 5'd25) ? 5'd0 : a + 5'd1;
    endfunction

    function automatic logic [4:0] clamp25(input logic [4:0] a);
        return (a > 5'd25) ? 5'd25 : a;
    endfunction

    logic [4:0]        r_pos_l, r_pos_m, r_pos_r;
    logic [4:0]        r_c;
    logic              r_s1_val;
    logic              r_wrg;
    logic [SYMB_W-1:0] r_out;
    logic              r_val;

    logic       w_sym_ok, w_accept, w_drop;
    logic       w_step_m, w_step_l;
    logic [4:0] w_c0;
    logic [4:0] w_c1, w_c2, w_c3, w_c4, w_c5, w_c6, w_c7;

    assign w_sym_ok = (in_en_i >= SYMB_W'(1)) && (in_en_i <= SYMB_W'(26));
    assign w_accept = en_val_i && !load_i && w_sym_ok;
    assign w_drop   = en_val_i && (load_i || !w_sym_ok);
    assign w_c0     = in_en_i[4:0] - 5'd1;

    // Middle rotor double-steps: it moves when the right rotor sits on its
    // notch and again when it sits on its own notch (carrying the left rotor).
    assign w_step_m = (r_pos_r == NOTCH_R) || (r_pos_m == NOTCH_M);
    assign w_step_l = (r_pos_m == NOTCH_M);

    // Stage 2 path; r_pos_* already hold the stepped positions for r_c.
    assign w_c1 = rot_fwd(SEL_III, r_c,  r_pos_r);
    assign w_c2 = rot_fwd(SEL_II,  w_c1, r_pos_m);
    assign w_c3 = rot_fwd(SEL_I,   w_c2, r_pos_l);
    assign w_c4 = lut(SEL_REF, w_c3);
    assign w_c5 = rot_inv(SEL_I,   w_c4, r_pos_l);
    assign w_c6 = rot_inv(SEL_II,  w_c5, r_pos_m);
    assign w_c7 = rot_inv(SEL_III, w_c6, r_pos_r);

    // Stage 1: capture the symbol and advance (or load) the rotor positions.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pos_l  <= 5'd0;
            r_pos_m  <= 5'd0;
            r_pos_r  <= 5'd0;
            r_c      <= 5'd0;
            r_s1_val <= 1'b0;
            r_wrg    <= 1'b0;
        end else begin
            r_s1_val <= w_accept;
            r_wrg    <= w_drop;
            if (w_accept) r_c <= w_c0;
            if (load_i) begin
                r_pos_l <= clamp25(pos_l_i);
                r_pos_m <= clamp25(pos_m_i);
                r_pos_r <= clamp25(pos_r_i);
            end else if (w_accept) begin
                r_pos_r <= inc26(r_pos_r);
                if (w_step_m) r_pos_m <= inc26(r_pos_m);
                if (w_step_l) r_pos_l <= inc26(r_pos_l);
            end
        end
    end

    // Stage 2: register the enciphered symbol.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_out <= '0;
            r_val <= 1'b0;
        end else begin
            r_val <= r_s1_val;
            r_out <= r_s1_val ? (SYMB_W'(w_c7) + SYMB_W'(1)) : '0;
        end
    end

    assign out_en_o    = r_out;
    assign encod_val_o = r_val;
    assign wrg_symb_o  = r_wrg;
    assign pos_o       = {r_pos_l, r_pos_m, r_pos_r};

endmodule

// File: tb/tb_enigma_core.sv
// Bench for enigma_core.  Reference model works on letter strings and plain
// integer arithmetic; per-cycle expectations flow through queues.
module tb_enigma_core;

  logic        clk;
  logic        rst_i;
  logic [6:0]  in_en_i;
  logic        en_val_i;
  logic        load_i;
  logic [4:0]  pos_l_i, pos_m_i, pos_r_i;
  logic [6:0]  out_en_o;
  logic        encod_val_o;
  logic        wrg_symb_o;
  logic [14:0] pos_o;

  int checks = 0;
  int errors = 0;

  // Expected {valid, symbol} two cycles out, wrong pulse and positions one cycle out.
  logic [7:0]  exp_q[$];
  logic        wrg_q[$];
  logic [14:0] pos_q[$];

  int m_l, m_m, m_r;

  string w_rot1 = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
  string w_rot2 = "AJDKSIRUXBLHWTMCQGZNPYVOEF";
  string w_rot3 = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
  string w_refl = "YRUHQSLDPXNGOKMIEBFZCWVJAT";

  enigma_core dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .in_en_i    (in_en_i),
    .en_val_i   (en_val_i),
    .load_i     (load_i),
    .pos_l_i    (pos_l_i),
    .pos_m_i    (pos_m_i),
    .pos_r_i    (pos_r_i),
    .out_en_o   (out_en_o),
    .encod_val_o(encod_val_o),
    .wrg_symb_o (wrg_symb_o),
    .pos_o      (pos_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int m_fwd(string w, int c, int p);
    return (int'(w[(c + p) % 26]) - 65 - p + 26) % 26;
  endfunction

  function automatic int m_inv(string w, int c, int p);
    int t = (c + p) % 26;
    for (int j = 0; j < 26; j++)
      if (int'(w[j]) - 65 == t) return (j - p + 26) % 26;
    return 0;
  endfunction

  function automatic int m_encipher(int sym, int pl, int pm, int pr);
    int c = sym - 1;
    c = m_fwd(w_rot3, c, pr);
    c = m_fwd(w_rot2, c, pm);
    c = m_fwd(w_rot1, c, pl);
    c = int'(w_refl[c]) - 65;
    c = m_inv(w_rot1, c, pl);
    c = m_inv(w_rot2, c, pm);
    c = m_inv(w_rot3, c, pr);
    return c + 1;
  endfunction

  task automatic init_model();
    m_l = 0; m_m = 0; m_r = 0;
    exp_q.delete(); wrg_q.delete(); pos_q.delete();
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    wrg_q.push_back(1'b0);
    pos_q.push_back(15'h0);
  endtask

  // ---------------- driver ----------------
  task automatic drive_idle();
    en_val_i = 1'b0; in_en_i = 7'd0; load_i = 1'b0;
    pos_l_i = 5'd0; pos_m_i = 5'd0; pos_r_i = 5'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    init_model();
  endtask

  // One cycle: sample outputs (obs), pop what the model predicted (expv),
  // then drive this cycle's inputs and extend the model.
  // Packing: {valid, sym[6:0], wrg, pos[14:0]}.
  task automatic tick(input logic v, input logic [6:0] s, input logic ld,
                      input logic [4:0] pl, input logic [4:0] pm, input logic [4:0] pr,
                      output logic [23:0] obs, output logic [23:0] expv);
    logic [7:0]  e_o;
    logic        e_w;
    logic [14:0] e_p;
    int sym;
    @(negedge clk);
    obs = {encod_val_o, out_en_o, wrg_symb_o, pos_o};
    e_o = exp_q.pop_front();
    e_w = wrg_q.pop_front();
    e_p = pos_q.pop_front();
    expv = {e_o, e_w, e_p};
    en_val_i = v; in_en_i = s; load_i = ld;
    pos_l_i = pl; pos_m_i = pm; pos_r_i = pr;
    sym = int'(s);
    if (ld) begin
      m_l = (int'(pl) > 25) ? 25 : int'(pl);
      m_m = (int'(pm) > 25) ? 25 : int'(pm);
      m_r = (int'(pr) > 25) ? 25 : int'(pr);
      exp_q.push_back(8'h00);
      wrg_q.push_back(v);
    end else if (v && sym >= 1 && sym <= 26) begin
      // Notches: rotor II at E, rotor III at V; tested before stepping.
      if (m_m == "E" - "A") begin
        m_l = (m_l + 1) % 26;
        m_m = (m_m + 1) % 26;
      end else if (m_r == "V" - "A") begin
        m_m = (m_m + 1) % 26;
      end
      m_r = (m_r + 1) % 26;
      exp_q.push_back({1'b1, 7'(m_encipher(sym, m_l, m_m, m_r))});
      wrg_q.push_back(1'b0);
    end else begin
      exp_q.push_back(8'h00);
      wrg_q.push_back(v);
    end
    pos_q.push_back({5'(m_l), 5'(m_m), 5'(m_r)});
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [23:0] obs, expv;
    repeat (2) @(negedge clk);
    checks++;
    if ({encod_val_o, out_en_o, wrg_symb_o, pos_o} !== 24'h0) begin
      errors++;
      $display("FAIL reset_initial: got %h expected 000000", {encod_val_o, out_en_o, wrg_symb_o, pos_o});
    end
    rst_i = 1'b0;
    init_model();
    tick(1'b0, 7'd0, 1'b1, 5'd5, 5'd6, 5'd7, obs, expv);
    tick(1'b1, 7'd3, 1'b0, 5'd0, 5'd0, 5'd0, obs, expv);
    tick(1'b0, 7'd0, 1'b0, 5'd0, 5'd0, 5'd0, obs, expv);
    checks++;
    if (obs !== expv) begin
      errors++; $display("FAIL reset_pre: got %h expected %h", obs, expv);
    end
    // Asynchronous: outputs must clear without a clock edge.
    drive_idle();
    rst_i = 1'b1;
    #1;
    checks++;
    if ({encod_val_o, out_en_o, wrg_symb_o, pos_o} !== 24'h0) begin
      errors++;
      $display("FAIL reset_async: got %h expected 000000", {encod_val_o, out_en_o, wrg_symb_o, pos_o});
    end
    do_reset();
  endtask

  task automatic test_encipher();
    logic [23:0] obs, expv;
    logic [6:0] ans [5];
    ans = '{7'd2, 7'd4, 7'd26, 7'd7, 7'd15};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      tick(i < 5, 7'd1, 1'b0, 5'd0, 5'd0, 5'd0, obs, expv);
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL encipher_model: i=%0d got %h expected %h", i, obs, expv);
      end
      checks++;
      if (i >= 2 && i <= 6) begin
        if (obs[23:16] !== {1'b1, ans[i-2]}) begin
          errors++; $display("FAIL encipher_known: i=%0d got %h expected %h", i, obs[23:16], {1'b1, ans[i-2]});
        end
      end else if (obs[23] !== 1'b0) begin
        errors++; $display("FAIL encipher_idle_valid: i=%0d got %b expected 0", i, obs[23]);
      end
    end
    checks++;
    if (obs[14:0] !== {5'd0, 5'd0, 5'd5}) begin
      errors++; $display("FAIL encipher_pos: got %h expected %h", obs[14:0], {5'd0, 5'd0, 5'd5});
    end
  endtask

  task automatic test_double_step();
    logic [23:0] obs, expv;
    logic [14:0] want [4];
    want = '{{5'd0, 5'd3, 5'd20}, {5'd0, 5'd3, 5'd21}, {5'd0, 5'd4, 5'd22}, {5'd1, 5'd5, 5'd23}};
    do_reset();
    tick(1'b0, 7'd0, 1'b1, 5'd0, 5'd3, 5'd20, obs, expv);
    for (int i = 0; i < 6; i++) begin
      tick(i < 3, 7'($urandom_range(1, 26)), 1'b0, 5'd0, 5'd0, 5'd0, obs, expv);
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL dstep_model: i=%0d got %h expected %h", i, obs, expv);
      end
      if (i < 4) begin
        checks++;
        if (obs[14:0] !== want[i]) begin
          errors++; $display("FAIL dstep_pos: i=%0d got %h expected %h", i, obs[14:0], want[i]);
        end
      end
    end
  endtask

  task automatic test_reciprocity();
    logic [23:0] obs, expv;
    logic [6:0] msg[$];
    logic [6:0] ct[$];
    logic [6:0] pt[$];
    for (int i = 0; i < 5; i++) msg.push_back(7'd1);
    for (int i = 0; i < 7; i++) msg.push_back(7'($urandom_range(1, 26)));
    do_reset();
    tick(1'b0, 7'd0, 1'b1, 5'd0, 5'd0, 5'd0, obs, expv);
    for (int i = 0; i < msg.size() + 3; i++) begin
      tick(i < msg.size(), (i < msg.size()) ? msg[i] : 7'd0, 1'b0, 5'd0, 5'd0, 5'd0, obs, expv);
      if (obs[23]) ct.push_back(obs[22:16]);
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL recip_enc_model: i=%0d got %h expected %h", i, obs, expv);
      end
    end
    tick(1'b0, 7'd0, 1'b1, 5'd0, 5'd0, 5'd0, obs, expv);
    for (int i = 0; i < ct.size() + 3; i++) begin
      tick(i < ct.size(), (i < ct.size()) ? ct[i] : 7'd0, 1'b0, 5'd0, 5'd0, 5'd0, obs, expv);
      if (obs[23]) pt.push_back(obs[22:16]);
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL recip_dec_model: i=%0d got %h expected %h", i, obs, expv);
      end
    end
    checks++;
    if (ct.size() != msg.size() || pt.size() != msg.size()) begin
      errors++;
      $display("FAIL recip_count: got ct=%0d pt=%0d expected %0d", ct.size(), pt.size(), msg.size());
    end else begin
      for (int i = 0; i < msg.size(); i++) begin
        checks++;
        if (pt[i] !== msg[i]) begin
          errors++; $display("FAIL recip_roundtrip: i=%0d got %0d expected %0d", i, pt[i], msg[i]);
        end
        checks++;
        if (ct[i] === msg[i]) begin
          errors++; $display("FAIL recip_selfmap: i=%0d got %0d expected not %0d", i, ct[i], msg[i]);
        end
      end
    end
  endtask

  task automatic test_wrong_symbol();
    logic [23:0] obs, expv;
    logic [6:0] bad [2];
    bad = '{7'd0, 7'd27};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i < 2) tick(1'b1, bad[i], 1'b0, 5'd0, 5'd0, 5'd0, obs, expv);
      else       tick(i == 4, 7'd1, 1'b0, 5'd0, 5'd0, 5'd0, obs, expv);
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL wrong_model: i=%0d got %h expected %h", i, obs, expv);
      end
      if (i < 4) begin
        checks++;
        if ({obs[23], obs[15], obs[14:0]} !== {1'b0, (i == 1 || i == 2), 15'h0}) begin
          errors++;
          $display("FAIL wrong_pulse: i=%0d got val=%b wrg=%b pos=%h expected val=0 wrg=%b pos=0",
                   i, obs[23], obs[15], obs[14:0], (i == 1 || i == 2));
        end
      end
      if (i == 6) begin
        checks++;
        if (obs[23:16] !== {1'b1, 7'd2}) begin
          errors++; $display("FAIL wrong_after: got %h expected %h", obs[23:16], {1'b1, 7'd2});
        end
      end
    end
  endtask

  task automatic test_load_collision();
    logic [23:0] obs, expv;
    do_reset();
    tick(1'b1, 7'd1, 1'b1, 5'd3, 5'd30, 5'd7, obs, expv);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 7'd0, 1'b0, 5'd0, 5'd0, 5'd0, obs, expv);
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL collide_model: i=%0d got %h expected %h", i, obs, expv);
      end
      checks++;
      if ({obs[23], obs[15], obs[14:0]} !== {1'b0, (i == 0), 5'd3, 5'd25, 5'd7}) begin
        errors++;
        $display("FAIL collide_state: i=%0d got val=%b wrg=%b pos=%h expected val=0 wrg=%b pos=%h",
                 i, obs[23], obs[15], obs[14:0], (i == 0), {5'd3, 5'd25, 5'd7});
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [23:0] obs, expv;
    do_reset();
    tick(1'b1, 7'd1, 1'b0, 5'd0, 5'd0, 5'd0, obs, expv);
    tick(1'b1, 7'd5, 1'b0, 5'd0, 5'd0, 5'd0, obs, expv);
    @(posedge clk);
    #1;
    drive_idle();
    rst_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({encod_val_o, out_en_o, pos_o} !== 23'h0) begin
        errors++;
        $display("FAIL midrst_hold: i=%0d got %h expected 0", i, {encod_val_o, out_en_o, pos_o});
      end
    end
    rst_i = 1'b0;
    init_model();
    for (int i = 0; i < 4; i++) begin
      tick(i == 0, 7'd1, 1'b0, 5'd0, 5'd0, 5'd0, obs, expv);
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL midrst_model: i=%0d got %h expected %h", i, obs, expv);
      end
      checks++;
      if (obs[23:16] !== ((i == 2) ? {1'b1, 7'd2} : 8'h00)) begin
        errors++;
        $display("FAIL midrst_after: i=%0d got %h expected %h", i, obs[23:16],
                 (i == 2) ? {1'b1, 7'd2} : 8'h00);
      end
    end
  endtask

  task automatic test_random();
    logic [23:0] obs, expv;
    int kind;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      kind = $urandom_range(0, 19);
      if (kind == 0)
        tick(1'($urandom_range(0, 1)), 7'($urandom_range(0, 30)), 1'b1,
             5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             obs, expv);
      else if (kind == 1)
        tick(1'b1, ($urandom_range(0, 1) == 0) ? 7'd0 : 7'($urandom_range(27, 127)), 1'b0,
             5'd0, 5'd0, 5'd0, obs, expv);
      else if (kind < 4)
        tick(1'b0, 7'($urandom_range(0, 127)), 1'b0, 5'd0, 5'd0, 5'd0, obs, expv);
      else
        tick(1'b1, 7'($urandom_range(1, 26)), 1'b0, 5'd0, 5'd0, 5'd0, obs, expv);
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL random: i=%0d got %h expected %h", i, obs, expv);
      end
    end
  endtask

  // ---------------- main ----------------
  initial begin
    rst_i = 1'b1;
    drive_idle();
    init_model();
    test_reset();
    test_encipher();
    test_double_step();
    test_reciprocity();
    test_wrong_symbol();
    test_load_collision();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/enigma_core.md
Name: enigma_core

Overview:
- Cipher engine for the Enigma datapath: a three-rotor Enigma I (rotors I-II-III, left to right, reflector B, ring settings fixed at A).
- Accepts one plaintext symbol per cycle on the symbol-in/valid interface and returns the enciphered symbol on the symbol-out/valid interface a fixed 2 cycles later.
- It is the responder for the symbol buffer that feeds it symbols and collects the enciphered results.

Parameters:
- SYMB_W, 7, width of symbol buses; legal symbols are 1..26 (A..Z).
- LAT, 2, input-valid to output-valid latency in cycles; fixed, not configurable.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- in_en_i  in  SYMB_W  plaintext symbol, 1..26.
- en_val_i  in  1  in_en_i valid this cycle.
- load_i  in  1  load rotor start positions.
- pos_l_i  in  5  left rotor start position, 0..25.
- pos_m_i  in  5  middle rotor start position, 0..25.
- pos_r_i  in  5  right rotor start position, 0..25.
- out_en_o  out  SYMB_W  enciphered symbol, 1..26; 0 when not valid.
- encod_val_o  out  1  out_en_o valid.
- wrg_symb_o  out  1  one-cycle pulse: symbol dropped.
- pos_o  out  15  current positions {l,m,r}, 5 bits each.

Behaviour:
- Reset: positions become 0,0,0 (AAA); pipeline cleared; out_en_o = 0, encod_val_o = 0, wrg_symb_o = 0, pos_o = 0.
  - Reset mid-stream discards every in-flight symbol; no valid output appears for them.
- Wirings (index 0 = A):
  - Rotor I: EKMFLGDQVZNTOWYHXUSPAIBRCJ, notch Q (16).
  - Rotor II: AJDKSIRUXBLHWTMCQGZNPYVOEF, notch E (4).
  - Rotor III: BDFHJLCPRTXVZNYEIWGAKMUSQO, notch V (21).
  - Reflector B: YRUHQSLDPXNGOKMIEBFZCWVJAT.
- Accept: a symbol is accepted when en_val_i = 1, load_i = 0 and 1 <= in_en_i <= 26.
- Invalid symbols:
  - en_val_i = 1 with in_en_i outside 1..26 is dropped. Rotors do not step and no output is produced.
  - wrg_symb_o pulses the next cycle.
- Load: load_i = 1 registers pos_*_i into the positions.
  - load_i has priority over en_val_i. A symbol presented in the same cycle is dropped and wrg_symb_o pulses.
  - pos_*_i values above 25 are taken mod 32 and then clamped to 25.
- Stepping happens on acceptance, before enciphering. The new positions are used for that symbol.
  - Right rotor always steps.
  - Middle rotor steps if right == 21 or middle == 4 (double step).
  - Left rotor steps if middle == 4.
  - All steps wrap 25 -> 0.
- Path, with c = in_en_i - 1:
  - Forward through R, M, L; reflector; inverse through L, M, R.
  - Forward rotor at position p: c' = (W[(c+p) mod 26] - p) mod 26.
  - Inverse rotor: c' = (W^-1[(c+p) mod 26] - p) mod 26.
  - Output symbol = c_final + 1.
  - All mod-26 arithmetic is done without negatives: add 26 before subtracting.
- Pipeline: stage 1 registers c and the stepped positions; stage 2 computes the path and registers out_en_o and encod_val_o.
  - Back-to-back accepts every cycle are supported, with no bubbles or stalls.
  - The position update for accept k+1 uses the positions after accept k.
- pos_o reflects the registered positions: updated the cycle after an accept or load.

Test Plan:
- Encipher run: reset, then AAAAA (1,1,1,1,1) valid on 5 consecutive cycles -> outputs BDZGO (2,4,26,7,15), valid on cycles 3..7 after the first input; pos_o ends {0,0,5}.
- Double step: load {0,3,20} (ADU), then 3 symbols -> pos_o sequence {0,3,21}, {0,4,22}, {1,5,23}.
- Reciprocity: load AAA, encipher BDZGO; reload AAA, feed BDZGO -> AAAAA; no symbol ever maps to itself.
- Wrong symbol: in_en_i = 0, then 27, each with valid -> wrg_symb_o pulses twice, no encod_val_o, pos_o unchanged; next A still gives B.
- Load collision: load_i = 1 and en_val_i = 1 in the same cycle -> positions loaded, symbol dropped, wrg_symb_o pulses once, no output.
- Reset mid-stream: assert rst_i with 2 symbols in flight -> encod_val_o = 0 on all following cycles, pos_o = 0; after release, A -> B.
